// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Bit counter width: must hold 0..width so the count never wraps mid-operation.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the serial adder.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand and the result side.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out
  );

  // The adder itself.
  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out
  );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Latency: combinational.
// Backpressure: none.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder feeding one full_adder cell, LSB first.
// Latency: out_valid visible WIDTH edges after the operand handshake.
// Backpressure: result held until out_ready; no new operands accepted until then.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  import serial_adder_pkg::*;

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic [CNT_W-1:0] count;
  logic             carry;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             release_out;
  logic             last_bit;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             out_valid_q;

  // in_ready depends only on registered state and reset, never on in_valid.
  assign bus.in_ready = (state == IDLE) && rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign release_out  = out_valid_q && bus.out_ready;
  assign last_bit     = (count == LAST_BIT);

  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.out_valid = out_valid_q;

  full_adder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry),
    .s     (fa_s),
    .c_out (fa_c)
  );

  // New sum bit enters at the MSB so after WIDTH shifts the LSB lands at bit 0.
  generate
    if (WIDTH == 1) begin : g_sum_one
      assign sum_nxt = fa_s;
    end else begin : g_sum_wide
      assign sum_nxt = {fa_s, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = RUN;
      RUN:     if (last_bit)    state_nxt = DONE;
      DONE:    if (release_out) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Datapath: load operands, shift one bit per cycle, capture and hold the result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      count       <= '0;
      carry       <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.c_in;
            count <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nxt;
          carry  <= fa_c;
          count  <= count + CNT_ONE;
          if (last_bit) begin
            sum_q       <= sum_nxt;
            c_out_q     <= fa_c;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (release_out) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1.
// Latency: checks result timing relative to the operand handshake.
// Backpressure: exercises held results under out_ready=0.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands to the WIDTH=8 block and complete the handshake on the next edge.
  task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic c);
    bus8.a        = a;
    bus8.b        = b;
    bus8.c_in     = c;
    bus8.in_valid = 1'b1;
    check("in_ready_before_accept", 32'(bus8.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
  endtask

  // Count edges until out_valid appears; 0 means it never did within the budget.
  task automatic wait_out8(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus8.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int         lat;
    logic       seen;
    logic [8:0] exp9;

    rst            = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.c_in      = 1'b0;
    bus8.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.a         = '0;
    bus1.b         = '0;
    bus1.c_in      = 1'b0;
    bus1.out_ready = 1'b1;

    // Reset state: everything cleared, in_ready low while rst is low.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_sum",       32'(bus8.sum),       32'd0);
    check("rst_c_out",     32'(bus8.c_out),     32'd0);
    check("rst_in_ready",  32'(bus8.in_ready),  32'd0);
    check("rst_in_ready1", 32'(bus1.in_ready),  32'd0);
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus8.in_ready), 32'd1);

    // Carry ripples across all bits.
    accept8(8'hFF, 8'h01, 1'b0);
    check("ripple_busy", 32'(bus8.in_ready), 32'd0);
    wait_out8(lat);
    check("ripple_latency", 32'(lat), 32'd8);
    check("ripple_result", {23'd0, bus8.c_out, bus8.sum}, 32'h100);
    @(posedge clk);
    #1;
    check("ripple_release", 32'(bus8.out_valid), 32'd0);

    // Carry-in path.
    accept8(8'h5A, 8'hA5, 1'b1);
    wait_out8(lat);
    check("cin_latency", 32'(lat), 32'd8);
    check("cin_result", {23'd0, bus8.c_out, bus8.sum}, 32'h100);
    @(posedge clk);
    #1;
    accept8(8'h3C, 8'h0F, 1'b0);
    wait_out8(lat);
    check("nocarry_result", {23'd0, bus8.c_out, bus8.sum}, 32'h04B);
    @(posedge clk);
    #1;

    // Output backpressure: result held, new operands ignored.
    bus8.out_ready = 1'b0;
    accept8(8'h3C, 8'h0F, 1'b0);
    wait_out8(lat);
    check("bp_latency", 32'(lat), 32'd8);
    bus8.a        = 8'hFF;
    bus8.b        = 8'hFF;
    bus8.c_in     = 1'b1;
    bus8.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_result", {22'd0, bus8.out_valid, bus8.c_out, bus8.sum}, 32'h04B | 32'h200);
      check("bp_in_ready",    32'(bus8.in_ready), 32'd0);
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(bus8.out_valid), 32'd0);
    check("bp_release_ready", 32'(bus8.in_ready),  32'd1);

    // Reset after 4 bits: operation discarded.
    accept8(8'hFF, 8'hFF, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_in_ready_low", 32'(bus8.in_ready), 32'd0);
    check("midrst_outputs", {22'd0, bus8.out_valid, bus8.c_out, bus8.sum}, 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_in_ready_high", 32'(bus8.in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus8.out_valid) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    accept8(8'h10, 8'h20, 1'b0);
    wait_out8(lat);
    check("after_rst_result", {23'd0, bus8.c_out, bus8.sum}, 32'h030);
    @(posedge clk);
    #1;

    // Back-to-back with in_valid held high and out_ready tied high.
    bus8.out_ready = 1'b1;
    bus8.a         = 8'($urandom);
    bus8.b         = 8'($urandom);
    bus8.c_in      = 1'($urandom);
    bus8.in_valid  = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      exp9 = {1'b0, bus8.a} + {1'b0, bus8.b} + {8'd0, bus8.c_in};
      @(posedge clk);
      #1;
      check("b2b_accepted", 32'(bus8.in_ready), 32'd0);
      wait_out8(lat);
      check("b2b_result", {23'd0, bus8.c_out, bus8.sum}, {23'd0, exp9} | (lat == 8 ? 32'd0 : 32'h8000_0000));
      @(posedge clk);
      #1;
      check("b2b_ready_again", 32'(bus8.in_ready), 32'd1);
      bus8.a    = 8'($urandom);
      bus8.b    = 8'($urandom);
      bus8.c_in = 1'($urandom);
    end
    bus8.in_valid = 1'b0;

    // WIDTH=1 instance: 1 + 1 + 1 = 2'b11.
    bus1.a        = 1'b1;
    bus1.b        = 1'b1;
    bus1.c_in     = 1'b1;
    bus1.in_valid = 1'b1;
    check("w1_ready", 32'(bus1.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    check("w1_running", {30'd0, bus1.out_valid, bus1.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("w1_result", {29'd0, bus1.out_valid, bus1.c_out, bus1.sum}, 32'h7);
    @(posedge clk);
    #1;
    check("w1_release", {30'd0, bus1.out_valid, bus1.in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
